mmio_port_responder: RTL and testbench
======================================

MMIO_PORT_RESPONDER -- requirements
Module: mmio_port_responder

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1001_0000: byte base of the 16-byte register window; bits [3:0] SHALL be zero.
REQ-002 Parameter IN_WIDTH, default 8: width of PortIn and of the edge/mask registers.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset; it SHALL clear all state immediately, regardless of clk.
REQ-005 Address  input  32  byte address from the processor MEM stage (ALU result).
REQ-006 WriteData  input  32  store data.
REQ-007 MemRead  input  1  load strobe for the current cycle.
REQ-008 MemWrite  input  1  store strobe for the current cycle.
REQ-009 ReadData  output  32  load data, combinational from Address and current register state.
REQ-010 PortIn  input  IN_WIDTH  asynchronous external input pins.
REQ-011 PortOut  output  32  output port register.
REQ-012 Irq  output  1  registered interrupt request.

Function
REQ-013 The block SHALL be selected when Address[31:4] == BASE_ADDR[31:4] and Address[1:0] == 2'b00; the register is chosen by offset Address[3:2].
REQ-014 Register map:
- 0x0 PORT_OUT: RW, 32 bits.
- 0x4 PORT_IN: RO, zero-extended synchronized input.
- 0x8 EDGE_STS: rising-edge flags, write-1-to-clear.
- 0xC EDGE_MASK: RW, IN_WIDTH bits, upper bits read 0.
REQ-015 Write rule: a selected register SHALL be written at the clk edge on which MemWrite=1; with MemWrite=0 nothing is written.
REQ-016 Writes to PORT_IN SHALL be ignored.
REQ-017 EDGE_MASK writes SHALL take WriteData[IN_WIDTH-1:0].
REQ-018 Read rule: when selected and MemRead=1, ReadData SHALL return the addressed register in the same cycle; in all other cases ReadData SHALL be 32'h0.
REQ-019 When MemRead=1 and MemWrite=1 together, the write SHALL occur and ReadData SHALL show the pre-write value for that cycle.
REQ-020 Unselected or misaligned accesses SHALL have no side effects.
REQ-021 PortOut SHALL equal PORT_OUT, with no extra latency after the write edge.
REQ-022 PortIn SHALL pass through a two-flop synchronizer (sync1, sync2) per bit. PORT_IN SHALL reflect sync2.
REQ-023 A prev register SHALL hold sync2 delayed by one clk. A rising edge on bit i is sync2[i]=1 and prev[i]=0.
REQ-024 If PortIn[i] rises before edge k, then:
- sync2[i]=1 after edge k+1;
- EDGE_STS[i]=1 after edge k+2;
- Irq=1 after edge k+3, if masked in.
REQ-025 Falling edges SHALL NOT set EDGE_STS.
REQ-026 EDGE_STS bits SHALL be sticky until cleared by writing 1 to them; writing 0 SHALL leave a bit unchanged.
REQ-027 If a W1C clear and a new rising edge hit the same bit on the same clk, the bit SHALL end set (set wins).
REQ-028 Each clk, Irq SHALL register |(EDGE_STS & EDGE_MASK) as evaluated before that edge's updates.
REQ-029 Clearing the mask or the status SHALL drop Irq one clk after the register change.
REQ-030 A pulse shorter than one clk period MAY be missed; no pulse-stretching is required.

Reset
REQ-031 While reset=1, the following SHALL all be 0: PORT_OUT, PortOut, EDGE_STS, EDGE_MASK, sync1, sync2, prev and Irq.
REQ-032 Because prev resets to 0, an input already high at reset release SHALL produce exactly one EDGE_STS set once it reaches sync2; this is defined behaviour.
REQ-033 Reset asserted mid-access SHALL abort the access; no write SHALL take effect.

Verification
REQ-034 Store 32'hDEAD_BEEF to 0x1001_0000 -> PortOut=32'hDEAD_BEEF after that edge; a load from the same address returns it.
REQ-035 PortIn 8'h00->8'h05 before edge k -> PORT_IN reads 32'h05 after edge k+1; EDGE_STS reads 32'h05 after k+2.
REQ-036 EDGE_MASK=8'h04, rising edges on bits 0 and 2 -> Irq=1 at k+3. Store 32'h04 to 0x1001_0008 -> EDGE_STS=32'h01 and Irq=0 one clk later.
REQ-037 W1C of bit 3 on the same edge that bit 3 is set -> EDGE_STS[3]=1 afterwards.
REQ-038 Store to 0x1001_0002 (misaligned) and to 0x1002_0000 (unselected) -> no register change; ReadData=0 for loads to those addresses.
REQ-039 Assert reset between clk edges with PORT_OUT=32'h1234 -> PortOut=0 immediately, before the next clk edge.

Source files
------------

// File: rtl/mmio_port_responder.sv
// Memory-mapped GPIO responder with PORT_OUT, PORT_IN, W1C EDGE_STS and EDGE_MASK registers.
// Latency: loads return in the same cycle; stores land on the clk edge; inputs reach PORT_IN after 2 edges.
// Backpressure: none; every access completes in the cycle it is presented.
module mmio_port_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h1001_0000,
  parameter int          IN_WIDTH  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         Address,
  input  logic [31:0]         WriteData,
  input  logic                MemRead,
  input  logic                MemWrite,
  output logic [31:0]         ReadData,
  input  logic [IN_WIDTH-1:0] PortIn,
  output logic [31:0]         PortOut,
  output logic                Irq
);

  localparam logic [1:0] OFF_PORT_OUT  = 2'd0;
  localparam logic [1:0] OFF_PORT_IN   = 2'd1;
  localparam logic [1:0] OFF_EDGE_STS  = 2'd2;
  localparam logic [1:0] OFF_EDGE_MASK = 2'd3;

  logic                sel;
  logic [1:0]          offset;
  logic                wrEn;
  logic [31:0]         portOutReg;
  logic [IN_WIDTH-1:0] sync1;
  logic [IN_WIDTH-1:0] sync2;
  logic [IN_WIDTH-1:0] prevIn;
  logic [IN_WIDTH-1:0] edgeSts;
  logic [IN_WIDTH-1:0] edgeMask;
  logic [IN_WIDTH-1:0] riseDet;
  logic [IN_WIDTH-1:0] stsClr;
  logic                irqReg;

  // Word-aligned hits inside the 16-byte window only; anything else is invisible.
  assign sel     = (Address[31:4] == BASE_ADDR[31:4]) && (Address[1:0] == 2'b00);
  assign offset  = Address[3:2];
  assign wrEn    = sel && MemWrite;

  // A rising edge is seen when the synchronized value is high and was low one clk earlier.
  assign riseDet = sync2 & ~prevIn;
  assign stsClr  = (wrEn && (offset == OFF_EDGE_STS)) ? WriteData[IN_WIDTH-1:0] : '0;

  assign PortOut = portOutReg;
  assign Irq     = irqReg;

  // Two-flop synchronizer for the asynchronous pins, plus a delayed copy for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1  <= '0;
      sync2  <= '0;
      prevIn <= '0;
    end else begin
      sync1  <= PortIn;
      sync2  <= sync1;
      prevIn <= sync2;
    end
  end

  // Output port register, driven straight onto PortOut.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      portOutReg <= '0;
    end else if (wrEn && (offset == OFF_PORT_OUT)) begin
      portOutReg <= WriteData;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgeMask <= '0;
    end else if (wrEn && (offset == OFF_EDGE_MASK)) begin
      edgeMask <= WriteData[IN_WIDTH-1:0];
    end
  end

  // Sticky edge flags: clear first, then OR in new edges so a simultaneous edge wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edgeSts <= '0;
    end else begin
      edgeSts <= (edgeSts & ~stsClr) | riseDet;
    end
  end

  // Interrupt samples the pre-edge status and mask, so it trails register changes by one clk.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irqReg <= 1'b0;
    end else begin
      irqReg <= |(edgeSts & edgeMask);
    end
  end

  // Combinational load path; registers are read before any same-cycle write lands.
  always_comb begin
    ReadData = '0;
    if (sel && MemRead) begin
      case (offset)
        OFF_PORT_OUT:  ReadData = portOutReg;
        OFF_PORT_IN:   ReadData[IN_WIDTH-1:0] = sync2;
        OFF_EDGE_STS:  ReadData[IN_WIDTH-1:0] = edgeSts;
        OFF_EDGE_MASK: ReadData[IN_WIDTH-1:0] = edgeMask;
        default:       ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_port_responder.sv
// Self-checking bench for mmio_port_responder: directed vector table, corner sequences, random run.
// Latency: one access per clk; inputs driven on the falling edge, outputs sampled away from the rising edge.
// Backpressure: not applicable; the bench drives one access per cycle.
module tb_mmio_port_responder;

  localparam logic [31:0] BASE = 32'h1001_0000;
  localparam logic [31:0] A_PO = BASE + 32'h0;
  localparam logic [31:0] A_PI = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_MK = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] ReadData;
  logic [7:0]  PortIn;
  logic [31:0] PortOut;
  logic        Irq;

  int checks = 0;
  int errors = 0;

  mmio_port_responder #(.BASE_ADDR(BASE), .IN_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .Address(Address), .WriteData(WriteData),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData),
    .PortIn(PortIn), .PortOut(PortOut), .Irq(Irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference model: architectural registers plus a history of pin values sampled on each edge.
  // pinHist[0] is the value sampled on the latest edge, pinHist[1] the one before, and so on.
  logic [31:0] mOut;
  logic [7:0]  mMask;
  logic [7:0]  mSts;
  logic        mIrq;
  logic [7:0]  pinHist [3];

  task automatic mReset();
    mOut = '0; mMask = '0; mSts = '0; mIrq = 1'b0;
    for (int i = 0; i < 3; i++) pinHist[i] = '0;
  endtask

  function automatic logic mSel(input logic [31:0] a);
    return (a[31:4] == BASE[31:4]) && (a[1:0] == 2'b00);
  endfunction

  // PORT_IN shows the pin value as it was two edges ago.
  function automatic logic [31:0] mRead(input logic [31:0] a, input logic rd);
    if (!rd || !mSel(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return mOut;
      2'd1:    return {24'h0, pinHist[1]};
      2'd2:    return {24'h0, mSts};
      default: return {24'h0, mMask};
    endcase
  endfunction

  // One clk edge: an input high two samples back but low three samples back is a new edge.
  task automatic mEdge(input logic [31:0] a, input logic [31:0] wd, input logic wr, input logic [7:0] pin);
    logic [7:0] newEdges;
    newEdges = pinHist[1] & ~pinHist[2];
    mIrq = |(mSts & mMask);
    if (wr && mSel(a)) begin
      case (a[3:2])
        2'd0:    mOut = wd;
        2'd2:    mSts = mSts & ~wd[7:0];
        2'd3:    mMask = wd[7:0];
        default: ;
      endcase
    end
    mSts = mSts | newEdges;
    pinHist[2] = pinHist[1];
    pinHist[1] = pinHist[0];
    pinHist[0] = pin;
  endtask

  // One access cycle; called on a falling edge, returns on the next falling edge.
  task automatic cycle(input string tag, input logic [31:0] a, input logic [31:0] wd,
                       input logic rd, input logic wr, input logic [7:0] pin,
                       output logic [31:0] rdSeen);
    Address = a; WriteData = wd; MemRead = rd; MemWrite = wr; PortIn = pin;
    #1;
    rdSeen = ReadData;
    check({tag, " ReadData vs model"}, ReadData, mRead(a, rd));
    @(posedge clk);
    mEdge(a, wd, wr, pin);
    @(negedge clk);
    check({tag, " PortOut vs model"}, PortOut, mOut);
    check({tag, " Irq vs model"}, {31'b0, Irq}, {31'b0, mIrq});
  endtask

  task automatic idleInputs(input logic [7:0] pin);
    Address = '0; WriteData = '0; MemRead = 1'b0; MemWrite = 1'b0; PortIn = pin;
  endtask

  task automatic doReset(input logic [7:0] pin);
    idleInputs(pin);
    reset = 1'b1;
    mReset();
    @(negedge clk);
    @(negedge clk);
    check("reset PortOut", PortOut, 32'h0);
    check("reset Irq", {31'b0, Irq}, 32'h0);
    Address = A_ST; MemRead = 1'b1;
    #1 check("reset EDGE_STS", ReadData, 32'h0);
    Address = A_MK;
    #1 check("reset EDGE_MASK", ReadData, 32'h0);
    Address = A_PI;
    #1 check("reset PORT_IN", ReadData, 32'h0);
    @(negedge clk);
    idleInputs(pin);
    reset = 1'b0;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    logic [7:0]  pin;
    logic [31:0] expRd;
    logic        expIrq;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [31:0] addr, input logic [31:0] wd, input logic rd,
                              input logic wr, input logic [7:0] pin, input logic [31:0] expRd,
                              input logic expIrq);
    vec_t v;
    v.addr = addr; v.wd = wd; v.rd = rd; v.wr = wr; v.pin = pin; v.expRd = expRd; v.expIrq = expIrq;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] seen;
    logic [7:0]  pin;
    logic [31:0] a;
    logic [31:0] wd;
    logic        rd;
    logic        wr;
    int          r;

    // Directed timeline from reset; ReadData is the pre-edge load, Irq is after the edge.
    vecs.push_back(mk(A_PO, 32'hDEAD_BEEF, 0, 1, 8'h00, 32'h0,         0));
    vecs.push_back(mk(A_PO, 32'h0,         1, 0, 8'h00, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(A_MK, 32'h0000_0004, 0, 1, 8'h00, 32'h0,         0));
    vecs.push_back(mk(A_MK, 32'h0,         1, 0, 8'h05, 32'h4,         0)); // pins rise before edge k
    vecs.push_back(mk(A_PI, 32'h0,         1, 0, 8'h05, 32'h0,         0)); // edge k+1
    vecs.push_back(mk(A_PI, 32'h0,         1, 0, 8'h05, 32'h5,         0)); // edge k+2 sets status
    vecs.push_back(mk(A_ST, 32'h0,         1, 0, 8'h05, 32'h5,         1)); // edge k+3 raises Irq
    vecs.push_back(mk(A_ST, 32'h0000_0004, 1, 1, 8'h05, 32'h5,         1)); // W1C bit 2, pre-write read
    vecs.push_back(mk(A_ST, 32'h0,         1, 0, 8'h05, 32'h1,         0));
    vecs.push_back(mk(BASE + 32'h2, 32'hFFFF_FFFF, 1, 1, 8'h05, 32'h0, 0)); // misaligned
    vecs.push_back(mk(BASE + 32'hB, 32'h0000_00FF, 1, 1, 8'h05, 32'h0, 0)); // misaligned into STS word
    vecs.push_back(mk(32'h1002_0000, 32'h0, 1, 1, 8'h05, 32'h0,        0)); // unselected
    vecs.push_back(mk(A_PO, 32'h0,         1, 0, 8'h05, 32'hDEAD_BEEF, 0));
    vecs.push_back(mk(A_PI, 32'h0000_00FF, 1, 1, 8'h05, 32'h5,         0)); // PORT_IN is read-only
    vecs.push_back(mk(A_PI, 32'h0,         1, 0, 8'h05, 32'h5,         0));
    vecs.push_back(mk(A_ST, 32'h0,         1, 0, 8'h05, 32'h1,         0));
    vecs.push_back(mk(A_PO, 32'h0,         0, 0, 8'h05, 32'h0,         0)); // no MemRead -> 0
    vecs.push_back(mk(A_ST, 32'h0000_0001, 1, 1, 8'h00, 32'h1,         0)); // clear, pins fall
    vecs.push_back(mk(A_ST, 32'h0,         1, 0, 8'h00, 32'h0,         0));
    vecs.push_back(mk(A_ST, 32'h0,         1, 0, 8'h00, 32'h0,         0));
    vecs.push_back(mk(A_ST, 32'h0,         1, 0, 8'h00, 32'h0,         0)); // falling edge sets nothing

    reset = 1'b1;
    doReset(8'h00);

    for (int i = 0; i < vecs.size(); i++) begin
      cycle($sformatf("vec%0d", i), vecs[i].addr, vecs[i].wd, vecs[i].rd, vecs[i].wr, vecs[i].pin, seen);
      check($sformatf("vec%0d ReadData", i), seen, vecs[i].expRd);
      check($sformatf("vec%0d Irq", i), {31'b0, Irq}, {31'b0, vecs[i].expIrq});
      check($sformatf("vec%0d PortOut", i), PortOut, 32'hDEAD_BEEF);
    end

    // Asynchronous reset between edges, with a store pending: clears at once and blocks the store.
    cycle("po1234", A_PO, 32'h0000_1234, 0, 1, 8'h00, seen);
    check("po1234 PortOut", PortOut, 32'h0000_1234);
    Address = A_PO; WriteData = 32'hFFFF_FFFF; MemWrite = 1'b1; MemRead = 1'b0; PortIn = 8'h01;
    #2 reset = 1'b1;
    mReset();
    #1 check("async reset PortOut", PortOut, 32'h0);
    @(posedge clk);
    @(negedge clk);
    check("reset blocks store PortOut", PortOut, 32'h0);
    idleInputs(8'h01);
    @(negedge clk);
    reset = 1'b0;

    // Input already high at release produces exactly one status set.
    cycle("hiRel1", A_ST, 32'h0, 1, 0, 8'h01, seen); check("hiRel1 sts", seen, 32'h0);
    cycle("hiRel2", A_ST, 32'h0, 1, 0, 8'h01, seen); check("hiRel2 sts", seen, 32'h0);
    cycle("hiRel3", A_ST, 32'h0, 1, 0, 8'h01, seen); check("hiRel3 sts", seen, 32'h0);
    cycle("hiRel4", A_ST, 32'h0, 1, 0, 8'h01, seen); check("hiRel4 sts", seen, 32'h1);
    cycle("hiRel5", A_ST, 32'h1, 1, 1, 8'h01, seen); check("hiRel5 sts", seen, 32'h1);
    cycle("hiRel6", A_ST, 32'h0, 1, 0, 8'h01, seen); check("hiRel6 sts", seen, 32'h0);
    cycle("hiRel7", A_ST, 32'h0, 1, 0, 8'h01, seen); check("hiRel7 sts", seen, 32'h0);

    // W1C and a new edge on bit 3 at the same clk: the set wins.
    cycle("same1", A_ST, 32'h0, 1, 0, 8'h09, seen); check("same1 sts", seen, 32'h0);
    cycle("same2", A_ST, 32'h0, 1, 0, 8'h09, seen); check("same2 sts", seen, 32'h0);
    cycle("same3", A_ST, 32'h8, 1, 1, 8'h09, seen); check("same3 sts", seen, 32'h0);
    cycle("same4", A_ST, 32'h0, 1, 0, 8'h09, seen); check("same4 sts", seen, 32'h8);

    // Mask changes move Irq one clk after the register update.
    cycle("mask1", A_MK, 32'h8, 0, 1, 8'h09, seen); check("mask1 Irq", {31'b0, Irq}, 32'h0);
    cycle("mask2", A_MK, 32'h0, 1, 0, 8'h09, seen); check("mask2 Irq", {31'b0, Irq}, 32'h1);
    check("mask2 read", seen, 32'h8);
    cycle("mask3", A_MK, 32'h0, 0, 1, 8'h09, seen); check("mask3 Irq", {31'b0, Irq}, 32'h1);
    cycle("mask4", A_MK, 32'h0, 1, 0, 8'h09, seen); check("mask4 Irq", {31'b0, Irq}, 32'h0);

    // Randomized accesses and pin activity against the reference model.
    doReset(8'h00);
    pin = 8'h00;
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 9);
      if (r < 8)       a = BASE + {28'h0, r[1:0], 2'b00};
      else if (r == 8) a = BASE + {28'h0, 4'($urandom_range(0, 15))};
      else             a = $urandom;
      wd = $urandom;
      rd = 1'($urandom_range(0, 1));
      wr = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) pin = pin ^ (8'h01 << $urandom_range(0, 7));
      cycle($sformatf("rnd%0d", i), a, wd, rd, wr, pin, seen);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
